rotate_unit: RTL and testbench

- Sequential rotator for the OPR group-1 rotate micro-ops: RAR, RAL, RTR, RTL and BSW.
- It is the other end of the link-register interface. It consumes the link's current value (link feeds LINK_IN) and AC. It returns the new link value on LINK_OUT, strobed by LINK_CK into the link register's FROM_ROTATER/SET/LINK_CK inputs.
- Rotation is performed one bit position per SYSCLK, with a START/DONE handshake to the sequencer.

---
 rtl/rotate_unit_pkg.sv | 59 +++++
 rtl/rotate_unit_if.sv | 26 ++
 rtl/rotate_unit_step.sv | 35 +++
 rtl/rotate_unit.sv | 95 +++++++++
 tb/tb_rotate_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rotate_unit_pkg.sv
// Shared definitions for the rotate unit: OPBITS field positions, FSM state
// encoding, step-count constants and the op decoder.
package rotate_unit_pkg;

  // Bit positions of the raw IR bits inside OPBITS = {RAR, RAL, TWO}.
  localparam int unsigned OpbitRar = 2;
  localparam int unsigned OpbitRal = 1;
  localparam int unsigned OpbitTwo = 0;

  // Step counter width; comfortably covers BSW_STEPS for any sane WIDTH.
  localparam int unsigned CntW = 8;

  localparam logic [CntW-1:0] StepsNone = '0;
  localparam logic [CntW-1:0] StepsOne  = CntW'(1);
  localparam logic [CntW-1:0] StepsTwo  = CntW'(2);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFinish
  } state_e;

  // Everything the datapath needs to know about an accepted op.
  typedef struct packed {
    logic            left;
    logic            include_link;
    logic [CntW-1:0] steps;
  } op_cfg_t;

  // Anything not listed is a pass-through (zero steps).
  function automatic op_cfg_t decode_op(input logic [2:0]      opbits,
                                        input logic [CntW-1:0] bsw_steps);
    op_cfg_t cfg;
    cfg.left         = 1'b0;
    cfg.include_link = 1'b1;
    cfg.steps        = StepsNone;
    case ({opbits[OpbitRar], opbits[OpbitRal], opbits[OpbitTwo]})
      3'b100: cfg.steps = StepsOne;
      3'b010: begin
        cfg.left  = 1'b1;
        cfg.steps = StepsOne;
      end
      3'b101: cfg.steps = StepsTwo;
      3'b011: begin
        cfg.left  = 1'b1;
        cfg.steps = StepsTwo;
      end
      3'b001: begin
        // BSW: swap AC halves by rotating AC alone, link untouched.
        cfg.left         = 1'b1;
        cfg.include_link = 1'b0;
        cfg.steps        = bsw_steps;
      end
      default: cfg.steps = StepsNone;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/rotate_unit_if.sv
// Sequencer <-> rotator link.
// master: sequencer side (drives START, OPBITS, AC_IN, LINK_IN).
// slave : rotator side (drives AC_OUT, LINK_OUT, BUSY, DONE, LINK_CK).
interface rotate_unit_if #(
  parameter int unsigned WIDTH = 12
);
  logic             START;
  logic [2:0]       OPBITS;
  logic [WIDTH-1:0] AC_IN;
  logic             LINK_IN;
  logic [WIDTH-1:0] AC_OUT;
  logic             LINK_OUT;
  logic             BUSY;
  logic             DONE;
  logic             LINK_CK;

  modport master (
    output START, OPBITS, AC_IN, LINK_IN,
    input  AC_OUT, LINK_OUT, BUSY, DONE, LINK_CK
  );

  modport slave (
    input  START, OPBITS, AC_IN, LINK_IN,
    output AC_OUT, LINK_OUT, BUSY, DONE, LINK_CK
  );
endinterface

// File: rtl/rotate_unit_step.sv
// One combinational rotation step of {link, ac}.
// Ports: link/ac     current value
//        dir         1 = rotate left, 0 = rotate right
//        include_link 1 = 13-bit rotate through link, 0 = AC-only rotate
//        link_next/ac_next  value after the step
module rotate_unit_step #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             link,
  input  logic [WIDTH-1:0] ac,
  input  logic             dir,
  input  logic             include_link,
  output logic             link_next,
  output logic [WIDTH-1:0] ac_next
);

  always_comb begin
    link_next = link;
    ac_next   = ac;
    if (dir) begin
      if (include_link) begin
        {link_next, ac_next} = {ac, link};
      end else begin
        ac_next = {ac[WIDTH-2:0], ac[WIDTH-1]};
      end
    end else begin
      if (include_link) begin
        {link_next, ac_next} = {ac[0], link, ac[WIDTH-1:1]};
      end else begin
        ac_next = {ac[0], ac[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/rotate_unit.sv
// Sequential rotator for RAR/RAL/RTR/RTL/BSW, one bit position per SYSCLK.
// Ports: SYSCLK  system clock
//        CLEAR   asynchronous active-high reset
//        bus     slave side of rotate_unit_if (START/OPBITS/AC_IN/LINK_IN in,
//                AC_OUT/LINK_OUT/BUSY/DONE/LINK_CK out)
module rotate_unit
  import rotate_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned BSW_STEPS = WIDTH / 2
) (
  input logic         SYSCLK,
  input logic         CLEAR,
  rotate_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             incl_q, incl_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             link_q, link_d;

  logic [WIDTH-1:0] step_ac;
  logic             step_link;
  op_cfg_t          cfg;

  rotate_unit_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .link         (link_q),
    .ac           (ac_q),
    .dir          (left_q),
    .include_link (incl_q),
    .link_next    (step_link),
    .ac_next      (step_ac)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    incl_d  = incl_q;
    ac_d    = ac_q;
    link_d  = link_q;
    cfg     = decode_op(bus.OPBITS, CntW'(BSW_STEPS));
    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          ac_d    = bus.AC_IN;
          link_d  = bus.LINK_IN;
          left_d  = cfg.left;
          incl_d  = cfg.include_link;
          cnt_d   = cfg.steps;
          state_d = (cfg.steps != StepsNone) ? StShift : StFinish;
        end
      end
      StShift: begin
        ac_d   = step_ac;
        link_d = step_link;
        cnt_d  = cnt_q - StepsOne;
        if (cnt_q == StepsOne) begin
          state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      incl_q  <= 1'b0;
      ac_q    <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      incl_q  <= incl_d;
      ac_q    <= ac_d;
      link_q  <= link_d;
    end
  end

  assign bus.AC_OUT   = ac_q;
  assign bus.LINK_OUT = link_q;
  assign bus.BUSY     = (state_q != StIdle);
  assign bus.DONE     = (state_q == StFinish);
  assign bus.LINK_CK  = (state_q == StFinish);

endmodule

// File: tb/tb_rotate_unit.sv
module tb_rotate_unit;

  logic SYSCLK;
  logic CLEAR;
  int   n_checks;
  int   n_fail;

  rotate_unit_if #(.WIDTH(12)) bus ();

  rotate_unit #(
    .WIDTH(12)
  ) dut (
    .SYSCLK (SYSCLK),
    .CLEAR  (CLEAR),
    .bus    (bus)
  );

  initial begin
    SYSCLK = 1'b0;
    forever #5 SYSCLK = ~SYSCLK;
  end

  // Present a one-cycle START; returns at the negedge after the accepting edge (cycle 1).
  task automatic do_start(input logic [2:0] op, input logic [11:0] ac, input logic link);
    @(negedge SYSCLK);
    bus.START   = 1'b1;
    bus.OPBITS  = op;
    bus.AC_IN   = ac;
    bus.LINK_IN = link;
    @(negedge SYSCLK);
    bus.START   = 1'b0;
  endtask

  // Advance until DONE; lat = cycle number of DONE (0 on timeout).
  // shift = cycles seen with BUSY high and DONE low.
  task automatic run_wait(input int first, output int lat, output int shift);
    lat   = 0;
    shift = 0;
    for (int i = first; i <= 20; i++) begin
      if (bus.DONE) begin
        lat = i;
        break;
      end
      if (bus.BUSY) shift++;
      @(negedge SYSCLK);
    end
  endtask

  task automatic test_reset();
    CLEAR = 1'b1;
    bus.START = 1'b0; bus.OPBITS = 3'b000; bus.AC_IN = 12'o7777; bus.LINK_IN = 1'b1;
    #12;
    n_checks++;
    if ({bus.AC_OUT, bus.LINK_OUT, bus.BUSY, bus.DONE, bus.LINK_CK} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: ac=%o link=%b busy=%b done=%b lck=%b, required all 0",
               bus.AC_OUT, bus.LINK_OUT, bus.BUSY, bus.DONE, bus.LINK_CK);
    end
    @(negedge SYSCLK);
    CLEAR = 1'b0;
  endtask

  task automatic test_ral();
    int lat, sh;
    do_start(3'b010, 12'o4000, 1'b0);
    // Later input changes must not affect the op in flight.
    bus.OPBITS = 3'b001; bus.AC_IN = 12'o5555; bus.LINK_IN = 1'b1;
    run_wait(1, lat, sh);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL ral_latency: got %0d, required 2", lat); end
    n_checks++;
    if (bus.AC_OUT !== 12'o0000 || bus.LINK_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL ral_result: got ac=%o l=%b, required ac=0000 l=1", bus.AC_OUT, bus.LINK_OUT);
    end
    n_checks++;
    if (bus.LINK_CK !== 1'b1 || bus.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL ral_done_cycle: lck=%b busy=%b, required 1 1", bus.LINK_CK, bus.BUSY);
    end
    @(negedge SYSCLK);
    n_checks++;
    if (bus.DONE !== 1'b0 || bus.LINK_CK !== 1'b0 || bus.BUSY !== 1'b0 || bus.AC_OUT !== 12'o0000) begin
      n_fail++;
      $display("FAIL ral_after: done=%b lck=%b busy=%b ac=%o, required 0 0 0 0000",
               bus.DONE, bus.LINK_CK, bus.BUSY, bus.AC_OUT);
    end
  endtask

  task automatic test_rtr();
    int lat, sh;
    do_start(3'b101, 12'o0001, 1'b0);
    @(negedge SYSCLK);
    n_checks++;
    if (bus.AC_OUT !== 12'o0000 || bus.LINK_OUT !== 1'b1 || bus.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL rtr_mid: ac=%o l=%b done=%b, required 0000 1 0",
               bus.AC_OUT, bus.LINK_OUT, bus.DONE);
    end
    run_wait(2, lat, sh);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL rtr_latency: got %0d, required 3", lat); end
    n_checks++;
    if (bus.AC_OUT !== 12'o4000 || bus.LINK_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL rtr_result: got ac=%o l=%b, required ac=4000 l=0", bus.AC_OUT, bus.LINK_OUT);
    end
  endtask

  task automatic test_rar_rtl();
    int lat, sh;
    do_start(3'b100, 12'o0003, 1'b1);
    run_wait(1, lat, sh);
    n_checks++;
    if (lat !== 2 || bus.AC_OUT !== 12'o4001 || bus.LINK_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL rar: lat=%0d ac=%o l=%b, required 2 4001 1", lat, bus.AC_OUT, bus.LINK_OUT);
    end
    do_start(3'b011, 12'o4000, 1'b0);
    run_wait(1, lat, sh);
    n_checks++;
    if (lat !== 3 || bus.AC_OUT !== 12'o0001 || bus.LINK_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL rtl: lat=%0d ac=%o l=%b, required 3 0001 0", lat, bus.AC_OUT, bus.LINK_OUT);
    end
  endtask

  task automatic test_bsw();
    int lat, sh;
    do_start(3'b001, 12'o0077, 1'b1);
    run_wait(1, lat, sh);
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL bsw_latency: got %0d, required 7", lat); end
    n_checks++;
    if (sh !== 6) begin n_fail++; $display("FAIL bsw_busy_shift: got %0d, required 6", sh); end
    n_checks++;
    if (bus.AC_OUT !== 12'o7700 || bus.LINK_OUT !== 1'b1 || bus.LINK_CK !== 1'b1) begin
      n_fail++;
      $display("FAIL bsw_result: ac=%o l=%b lck=%b, required 7700 1 1",
               bus.AC_OUT, bus.LINK_OUT, bus.LINK_CK);
    end
  endtask

  task automatic test_pass();
    int lat, sh;
    do_start(3'b110, 12'o1234, 1'b1);
    run_wait(1, lat, sh);
    n_checks++;
    if (lat !== 1 || bus.AC_OUT !== 12'o1234 || bus.LINK_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_110: lat=%0d ac=%o l=%b, required 1 1234 1", lat, bus.AC_OUT, bus.LINK_OUT);
    end
    do_start(3'b000, 12'o6543, 1'b0);
    run_wait(1, lat, sh);
    n_checks++;
    if (lat !== 1 || bus.AC_OUT !== 12'o6543 || bus.LINK_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_000: lat=%0d ac=%o l=%b, required 1 6543 0", lat, bus.AC_OUT, bus.LINK_OUT);
    end
  endtask

  task automatic test_back_to_back();
    int lat, sh, extra;
    do_start(3'b001, 12'o0077, 1'b1);
    @(negedge SYSCLK);
    // START while busy, sampled at the edge ending cycle 2.
    bus.START = 1'b1; bus.OPBITS = 3'b010; bus.AC_IN = 12'o7777; bus.LINK_IN = 1'b0;
    @(negedge SYSCLK);
    bus.START = 1'b0;
    run_wait(3, lat, sh);
    n_checks++;
    if (lat !== 7 || bus.AC_OUT !== 12'o7700 || bus.LINK_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore: lat=%0d ac=%o l=%b, required 7 7700 1", lat, bus.AC_OUT, bus.LINK_OUT);
    end
    // START on the FINISH->IDLE edge must be dropped too.
    bus.START = 1'b1; bus.OPBITS = 3'b110; bus.AC_IN = 12'o1111; bus.LINK_IN = 1'b0;
    @(negedge SYSCLK);
    bus.START = 1'b0;
    n_checks++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.AC_OUT !== 12'o7700) begin
      n_fail++;
      $display("FAIL finish_start_ignore: done=%b busy=%b ac=%o, required 0 0 7700",
               bus.DONE, bus.BUSY, bus.AC_OUT);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.DONE || bus.LINK_CK) extra++;
      @(negedge SYSCLK);
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL extra_done: got %0d pulses, required 0", extra); end
  endtask

  task automatic test_clear();
    int lat, sh, pulses;
    do_start(3'b011, 12'o4000, 1'b0);
    CLEAR = 1'b1;
    #1;
    n_checks++;
    if ({bus.AC_OUT, bus.LINK_OUT, bus.BUSY, bus.DONE, bus.LINK_CK} !== 16'h0) begin
      n_fail++;
      $display("FAIL clear_abort: ac=%o l=%b busy=%b done=%b lck=%b, required all 0",
               bus.AC_OUT, bus.LINK_OUT, bus.BUSY, bus.DONE, bus.LINK_CK);
    end
    @(negedge SYSCLK);
    CLEAR = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.DONE || bus.LINK_CK || bus.BUSY) pulses++;
      @(negedge SYSCLK);
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL clear_no_done: got %0d, required 0", pulses); end
    do_start(3'b100, 12'o0002, 1'b1);
    run_wait(1, lat, sh);
    n_checks++;
    if (lat !== 2 || bus.AC_OUT !== 12'o4001 || bus.LINK_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_recover: lat=%0d ac=%o l=%b, required 2 4001 0",
               lat, bus.AC_OUT, bus.LINK_OUT);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ral();
    test_rtr();
    test_rar_rtl();
    test_bsw();
    test_pass();
    test_back_to_back();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
